// File: rtl/module_teclado_barrido.sv
// 4x4 matrix-keypad scanner: walks a low level across the rows, debounces the
// first detected press and its release, and strobes the row/column codes once per keypress.
module module_teclado_barrido #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] columna_i,
    output logic [3:0] fila_o,
    output logic       dato_listo_o,
    output logic [1:0] dato_codc_o,
    output logic [1:0] dato_codf_o
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_REPORT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    // Row drive pattern: the selected row pulled low, the others released high.
    function automatic logic [3:0] row_drive(input logic [1:0] row);
        logic [3:0] pat;
        case (row)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = 4'b1110;
        endcase
        return pat;
    endfunction

    // Lowest-index active-low column wins when several keys share a row.
    function automatic logic [1:0] low_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0]) begin
            idx = 2'd0;
        end else if (!cols[1]) begin
            idx = 2'd1;
        end else if (!cols[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    logic [3:0]       col_meta_q;
    logic [3:0]       col_s_q;
    state_t           state_q;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       fila_q;
    logic             dato_listo_q;
    logic [1:0]       dato_codc_q;
    logic [1:0]       dato_codf_q;

    logic [1:0]       row_next_d;
    logic             col_any_low_s;
    logic             col_held_s;
    logic             col_idle_s;

    // Two-flop synchronizer for the asynchronous column lines; idle level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= columna_i;
            col_s_q    <= col_meta_q;
        end
    end

    // Decode helpers derived from the synchronized columns and current row.
    always_comb begin
        row_next_d    = row_q + 2'd1;
        col_any_low_s = (col_s_q != 4'hF);
        col_idle_s    = (col_s_q == 4'hF);
        col_held_s    = ~col_s_q[col_q];
    end

    // Scanner FSM; row drive, strobe and codes are all registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_SCAN;
            row_q        <= 2'd0;
            col_q        <= 2'd0;
            cnt_q        <= CNT_ZERO;
            fila_q       <= 4'b1110;
            dato_listo_q <= 1'b0;
            dato_codc_q  <= 2'd0;
            dato_codf_q  <= 2'd0;
        end else begin
            dato_listo_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= CNT_ZERO;
                        if (col_any_low_s) begin
                            col_q   <= low_col(col_s_q);
                            state_q <= ST_DEBOUNCE;
                        end else begin
                            row_q  <= row_next_d;
                            fila_q <= row_drive(row_next_d);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_held_s) begin
                        if (cnt_q == DEB_LAST) begin
                            cnt_q        <= CNT_ZERO;
                            state_q      <= ST_REPORT;
                            dato_listo_q <= 1'b1;
                            dato_codc_q  <= row_q;
                            dato_codf_q  <= col_q;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Bounce: abandon this key and move on to the next row.
                        cnt_q   <= CNT_ZERO;
                        row_q   <= row_next_d;
                        fila_q  <= row_drive(row_next_d);
                        state_q <= ST_SCAN;
                    end
                end
                ST_REPORT: begin
                    cnt_q   <= CNT_ZERO;
                    state_q <= ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    if (col_idle_s) begin
                        if (cnt_q == DEB_LAST) begin
                            cnt_q   <= CNT_ZERO;
                            row_q   <= row_next_d;
                            fila_q  <= row_drive(row_next_d);
                            state_q <= ST_SCAN;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_q <= CNT_ZERO;
                    end
                end
                default: begin
                    state_q <= ST_SCAN;
                    cnt_q   <= CNT_ZERO;
                    row_q   <= 2'd0;
                    fila_q  <= 4'b1110;
                end
            endcase
        end
    end

    assign fila_o       = fila_q;
    assign dato_listo_o = dato_listo_q;
    assign dato_codc_o  = dato_codc_q;
    assign dato_codf_o  = dato_codf_q;

endmodule

// File: doc/module_teclado_barrido.md
Name: module_teclado_barrido

Overview:
Matrix-keypad scanner for the 4x4 keypad. It drives one keypad row low at a time and senses the four column lines. It debounces a detected press and emits a one-cycle ready strobe with the 2-bit row and column codes. It is the producer feeding the digit decoder: the decoder latches {dato_codc, dato_codf} on dato_listo as position 4*row+col. The block also debounces release, so exactly one report is produced per physical keypress.

Parameters:
SCAN_DIV, 1000, clk cycles each row is driven before its columns are sampled; must be >= 4.
DEBOUNCE_CNT, 500000, consecutive stable clk cycles required to accept a press or a release; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
columna_i  input  4  keypad column sense lines; active-low (pull-ups); asynchronous to clk
fila_o  output  4  keypad row drive; exactly one bit low (driven row), others high
dato_listo_o  output  1  one-cycle strobe: new key codes valid
dato_codc_o  output  2  row index of the pressed key (row 0 = keys 1,2,3,A; row 3 = *,0,#,D)
dato_codf_o  output  2  column index of the pressed key (column 0 = keys 1,4,7,*)

Behaviour:
- Reset (rst low, asynchronous):
  - State SCAN, row index 0, fila_o=4'b1110.
  - dato_listo_o=0, dato_codc_o=0, dato_codf_o=0.
  - All counters and synchronizer flops cleared; synchronizer flops reset to 1 (idle).
  - Reset asserted mid-operation aborts everything; no strobe is emitted.
- Synchronizer: columna_i passes through 2 flops (col_s). All decisions use col_s only.
- All outputs are registered. fila_o always equals ~(1 << row).
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1 with the current row driven.
  - At count SCAN_DIV-1, sample col_s.
  - If any bit is low: latch row, latch the lowest-index low column (priority col0 > col3), clear counters, go to DEBOUNCE.
  - Otherwise: row <= row+1 (3 wraps to 0), dwell counter restarts.
- DEBOUNCE:
  - Row stays driven. Counter increments each cycle that col_s[latched col] is low.
  - If that bit reads high on any cycle: advance row, go to SCAN. No strobe.
  - When the counter reaches DEBOUNCE_CNT-1 with the bit still low, go to REPORT.
- REPORT (exactly 1 cycle):
  - dato_codc_o/dato_codf_o load the latched row/col on entry and are valid during this cycle.
  - dato_listo_o=1 for this cycle only.
  - Go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Row stays driven. Counter increments while col_s==4'b1111; any low bit clears it.
  - At DEBOUNCE_CNT-1: advance row, go to SCAN.
  - No further strobes until release completes, including other keys pressed in the meantime.
- Codes hold their last reported value until the next REPORT. The downstream decoder may read them at any time.
- Press-to-strobe latency from a clean, stable press: at most 4*SCAN_DIV + 2 (sync) + DEBOUNCE_CNT + 1 cycles.
- Multiple keys:
  - Only the first-detected row is reported.
  - Within a row, the lowest column wins.
  - A second key held through release blocks rescanning until all columns are high.

Test Plan:
- Bench parameters SCAN_DIV=4, DEBOUNCE_CNT=8. Model the keypad as columna_i[c] = fila_o[r] while key (r,c) is pressed, 1 otherwise.
- Reset then idle 200 cycles -> fila_o cycles 1110, 1101, 1011, 0111 every 4 cycles; dato_listo_o stays 0; codes stay 0.
- Hold key '5' (row1, col1) 100 cycles -> exactly one dato_listo_o pulse with dato_codc_o=1, dato_codf_o=1 (decoder yields 4'd5). Release -> scanning resumes. Press '0' (row3, col1) -> codc=3, codf=1.
- Press '9' with 5-cycle bounce bursts (<DEBOUNCE_CNT stable), then a clean hold -> no strobe during the bounce; exactly one strobe with codc=2, codf=2 after a stable press.
- Hold '7' for 300 cycles, release with 3-cycle bounce, re-press -> exactly two strobes total, each codc=2, codf=0. No strobe until the release has been stable 8 cycles.
- Press keys (0,0) and (0,2) together -> one strobe with codc=0, codf=0. Releasing only (0,0) while holding (0,2) -> no strobe until both are released.
- Pull rst low during DEBOUNCE of key '3' -> fila_o=1110 and dato_listo_o=0 immediately (asynchronous); no strobe occurs. After rst is released with the key still held, one strobe with codc=0, codf=2.
